acc_cpu_mc: RTL and testbench
=============================

# acc_cpu_mc

Parametrised, multi-cycle successor to the team's 8-bit accumulator CPU. It keeps the same eight-opcode accumulator ISA but generalises data and address width. Memory moves out of the core onto a single req/ack memory port, so the core can sit in front of any RAM or ROM model or a shared bus. A small FSM sequences fetch, decode, operand access and halt.

## Interface
- DATA_W, default 8: accumulator, memory word and instruction width; must be ≥ ADDR_W+3.
- ADDR_W, default 5: program counter and operand address width.
- clk  in  1  rising-edge clock; sole clock.
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write (STO), 0 = read; valid while mem_req=1.
- mem_addr  out  ADDR_W  transaction address.
- mem_wdata  out  DATA_W  store data; valid while mem_req=1 and mem_we=1.
- mem_rdata  in  DATA_W  read data; sampled in the cycle mem_ack=1.
- mem_ack  in  1  transaction complete.
- HALT  out  1  core is in the HALTED state.
- pc_o  out  ADDR_W  current program counter (debug).
- ac_o  out  DATA_W  current accumulator (debug).
- resume  in  1  present only with ACC_CPU_RESUME_EN.

## Operation
- Instruction word: opcode = ir[DATA_W-1:DATA_W-3], operand = ir[ADDR_W-1:0]; bits between them are ignored.
- Opcodes:
  - 0 HLT
  - 1 SKZ: pc += 1 + (ac==0)
  - 2 ADD
  - 3 AND
  - 4 XOR
  - 5 LDA: ac = mem[operand]
  - 6 STO: mem[operand] = ac
  - 7 JMP: pc = operand
- ADD, AND and XOR use ac op mem[operand]; all are followed by pc += 1.
- Arithmetic: ADD is modulo 2^DATA_W with no carry kept. pc arithmetic is modulo 2^ADDR_W; SKZ at pc=max-1 or pc=max wraps.
- FSM states:
  - FETCH: mem_req=1, we=0, addr=pc. On ack, latch ir and go to DECODE.
  - DECODE:
    - HLT goes to HALTED.
    - SKZ/JMP update pc and go to FETCH.
    - ADD/AND/XOR/LDA go to OPRD.
    - STO goes to OPWR.
  - OPRD: read at operand. On ack, update ac, pc += 1, go to FETCH.
  - OPWR: write ac to operand. On ack, pc += 1, go to FETCH.
  - HALTED: no memory activity; HALT=1.
- Reset values: pc=0, ac=0, ir=0, state=FETCH, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, HALT=0.
- Reset mid-transaction: mem_req drops at the reset edge and the transaction is abandoned; the memory must tolerate this.
- mem_ack while mem_req=0 is ignored.

## Timing
- All outputs are registered.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are stable from assertion until the cycle mem_ack=1 is sampled.
  - mem_req is low for at least one cycle between transactions.
  - mem_ack may arrive in the first cycle of mem_req (zero wait).
- Zero-wait cycles per instruction, counting from the FETCH request cycle:
  - SKZ/JMP: 3 (FETCH, gap/DECODE, update).
  - ADD/AND/XOR/LDA/STO: 5.
  - Each memory wait state adds 1.
- HALT rises the cycle after DECODE of HLT. pc stays at the HLT address.
- ac_o and pc_o update on the same edge as the internal registers.

## Configuration
- ACC_CPU_RESUME_EN defined:
  - Adds the resume input.
  - In HALTED, resume=1 for one cycle sets pc += 1, clears HALT on the next edge and enters FETCH.
  - resume is ignored in every other state.
- ACC_CPU_RESUME_EN undefined: no resume port; HALTED is left only by reset.

## Structure
- acc_cpu_pkg holds:
  - opcode enum (OP_HLT … OP_JMP, 3-bit);
  - FSM state enum (ST_FETCH, ST_DECODE, ST_OPRD, ST_OPWR, ST_HALTED);
  - opcode field position constants, derived from DATA_W inside the core.
- One sub-module, acc_cpu_alu: combinational; inputs opcode, ac and operand data; output next ac for ADD/AND/XOR/LDA. The FSM, pc and handshake stay in acc_cpu_mc.

## Test plan
- Reset: hold rst=0 for 3 cycles with mem_ack=1 → mem_req=0, pc_o=0, ac_o=0, HALT=0; first mem_req with addr=0 appears after rst=1.
- Program at DATA_W=8, ADDR_W=5, zero wait: LDA 30 (mem[30]=0x0F), ADD 31 (mem[31]=0xF5), STO 29, HLT → mem[29]=0x04 (wrap), HALT=1, pc_o=3.
- SKZ: ac=0 at pc=4 → next fetch at 6. ac=1 → next fetch at 5. SKZ at pc=31 with ac=0 → fetch at 1.
- Wait states: random 0–4 cycle ack delay on the program above → identical final memory and ac; address/we/wdata stable across every wait cycle; req low ≥1 cycle between transactions.
- Reset asserted during an OPWR wait → no further mem_req until release; restart fetches address 0; ac_o=0.
- With ACC_CPU_RESUME_EN, DATA_W=12, ADDR_W=8: HLT at 0x10, then resume pulse → HALT falls and the next fetch address is 0x11. Without the macro, HALT stays 1 for 100 cycles.

Source files
------------

// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg: shared types and constants for the multi-cycle accumulator CPU.
//   opcode_e : 3-bit instruction opcodes (OP_HLT .. OP_JMP)
//   state_e  : core sequencer states
//   OPC_W    : opcode field width; opc_lsb() gives the field's low bit for a
//              given instruction width (the field always sits at the top).
package acc_cpu_pkg;

  localparam int OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_OPRD   = 3'd2,
    ST_OPWR   = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  function automatic int opc_lsb(input int data_w);
    return data_w - OPC_W;
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// acc_cpu_alu: combinational accumulator update for the data-reading opcodes.
//   opc_i     : opcode of the instruction being executed
//   ac_i      : current accumulator
//   rdata_i   : operand word read from memory
//   ac_next_o : new accumulator value (ADD/AND/XOR/LDA); ac_i otherwise
// ADD wraps modulo 2^DATA_W; the carry is discarded.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           opc_i,
  input  logic [DATA_W-1:0] ac_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] ac_next_o
);

  always_comb begin
    ac_next_o = ac_i;
    case (opc_i)
      OP_ADD:  ac_next_o = ac_i + rdata_i;
      OP_AND:  ac_next_o = ac_i & rdata_i;
      OP_XOR:  ac_next_o = ac_i ^ rdata_i;
      OP_LDA:  ac_next_o = rdata_i;
      default: ac_next_o = ac_i;
    endcase
  end

endmodule

// File: rtl/acc_cpu_mc.sv
// acc_cpu_mc: multi-cycle accumulator CPU with an external req/ack memory port.
//   clk, rst     : rising-edge clock, synchronous active-low reset
//   resume       : leave HALTED and continue at pc+1 (only when the
//                  ACC_CPU_RESUME_EN macro is defined)
//   mem_req/we/addr/wdata : registered memory request
//   mem_rdata/ack         : memory response
//   HALT         : core is halted
//   pc_o, ac_o   : program counter and accumulator (debug view)
// Build option: define ACC_CPU_RESUME_EN to add the resume input; without it
// HALTED is left only through reset.
//
// Memory handshake: the core raises mem_req together with mem_we, mem_addr
// and mem_wdata and holds all four unchanged until it samples mem_ack=1 on a
// rising edge; that edge completes the transfer (read data captured) and
// mem_req drops on it. Every transfer is preceded by a cycle with mem_req=0
// in which the request is set up, so back-to-back requests always have a gap
// and mem_ack seen while mem_req=0 is ignored. Ack may come in the first
// request cycle.
module acc_cpu_mc
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ACC_CPU_RESUME_EN
  input  logic              resume,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              HALT,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] ac_o
);

  localparam int OPC_MSB = DATA_W - 1;
  localparam int OPC_LSB = opc_lsb(DATA_W);

  state_e              state_q;
  // The instruction register keeps only the two fields the core uses; the
  // bits between opcode and operand are don't-care.
  opcode_e             opc_q;
  logic [ADDR_W-1:0]   opnd_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   ac_q;
  logic                req_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                halt_q;

  logic [ADDR_W-1:0]   pc_inc_d;
  logic [ADDR_W-1:0]   pc_skz_d;
  logic [DATA_W-1:0]   ac_alu_d;

  assign pc_inc_d = pc_q + ADDR_W'(1);
  // SKZ skips one word when the accumulator is zero; wraps modulo 2^ADDR_W.
  assign pc_skz_d = pc_q + ((ac_q == '0) ? ADDR_W'(2) : ADDR_W'(1));

  acc_cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .opc_i     (opc_q),
    .ac_i      (ac_q),
    .rdata_i   (mem_rdata),
    .ac_next_o (ac_alu_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      opc_q   <= OP_HLT;
      opnd_q  <= '0;
      pc_q    <= '0;
      ac_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= pc_q;
          end else if (mem_ack) begin
            opc_q   <= opcode_e'(mem_rdata[OPC_MSB:OPC_LSB]);
            opnd_q  <= mem_rdata[ADDR_W-1:0];
            req_q   <= 1'b0;
            state_q <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          case (opc_q)
            OP_HLT: begin
              halt_q  <= 1'b1;
              state_q <= ST_HALTED;
            end
            OP_SKZ: begin
              pc_q    <= pc_skz_d;
              state_q <= ST_FETCH;
            end
            OP_JMP: begin
              pc_q    <= opnd_q;
              state_q <= ST_FETCH;
            end
            OP_STO:  state_q <= ST_OPWR;
            default: state_q <= ST_OPRD;
          endcase
        end

        ST_OPRD: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= opnd_q;
          end else if (mem_ack) begin
            ac_q    <= ac_alu_d;
            pc_q    <= pc_inc_d;
            req_q   <= 1'b0;
            state_q <= ST_FETCH;
          end
        end

        ST_OPWR: begin
          if (!req_q) begin
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= opnd_q;
            wdata_q <= ac_q;
          end else if (mem_ack) begin
            pc_q    <= pc_inc_d;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= ST_FETCH;
          end
        end

        ST_HALTED: begin
`ifdef ACC_CPU_RESUME_EN
          if (resume) begin
            pc_q    <= pc_inc_d;
            halt_q  <= 1'b0;
            state_q <= ST_FETCH;
          end
`endif
        end

        default: state_q <= ST_FETCH;
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign HALT      = halt_q;
  assign pc_o      = pc_q;
  assign ac_o      = ac_q;

endmodule

// File: tb/tb_acc_cpu_mc.sv
// tb_acc_cpu_mc: bench for acc_cpu_mc. A behavioural memory answers the
// req/ack port with configurable wait states; every memory transaction the
// core should issue is queued up front and a monitor pops and compares each
// request as it appears, also watching request stability and the idle gap.
module tb_acc_cpu_mc;

`ifdef ACC_CPU_RESUME_EN
  localparam int DW = 12;
  localparam int AW = 8;
`else
  localparam int DW = 8;
  localparam int AW = 5;
`endif
  localparam int TW   = 1 + AW + DW;
  localparam int MEMN = 1 << AW;
  localparam logic [AW-1:0] AMAX = '1;

  logic          clk;
  logic          rst;
`ifdef ACC_CPU_RESUME_EN
  logic          resume;
`endif
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          HALT;
  logic [AW-1:0] pc_o;
  logic [DW-1:0] ac_o;

  logic [DW-1:0] mem [MEMN];
  logic [TW-1:0] exp_q [$];

  int   vectors;
  int   miscompares;
  int   max_wait;
  logic stall_we;
  logic ack_idle;

  acc_cpu_mc #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ACC_CPU_RESUME_EN
    .resume    (resume),
`endif
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .HALT      (HALT),
    .pc_o      (pc_o),
    .ac_o      (ac_o)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [DW-1:0] enc(input logic [2:0] op, input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = '0;
    w[DW-1:DW-3] = op;
    w[AW-1:0] = a;
    return w;
  endfunction

  function automatic logic [TW-1:0] txn(input logic we, input logic [AW-1:0] a,
                                        input logic [DW-1:0] d);
    return {we, a, (we ? d : {DW{1'b0}})};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_rd(input int a);
    exp_q.push_back(txn(1'b0, AW'(a), '0));
  endtask

  task automatic push_wr(input int a, input logic [DW-1:0] d);
    exp_q.push_back(txn(1'b1, AW'(a), d));
  endtask

  // ---------------- memory responder ----------------
  int   wait_cnt;
  logic in_txn;

  initial begin
    in_txn    = 1'b0;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
  end

  always @(negedge clk) begin
    if (!mem_req) begin
      in_txn  = 1'b0;
      mem_ack = ack_idle;
    end else begin
      if (!in_txn) begin
        in_txn   = 1'b1;
        wait_cnt = $urandom_range(max_wait, 0);
      end
      if (stall_we && mem_we) begin
        mem_ack = 1'b0;
      end else if (wait_cnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = wait_cnt - 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic          last_req;
  logic [TW-1:0] held;
  logic [TW-1:0] cur;
  logic [TW-1:0] exp_t;

  initial begin
    last_req = 1'b0;
    held     = '0;
  end

  always @(posedge clk) begin
    #1;
    cur = txn(mem_we, mem_addr, mem_wdata);
    if (!rst) begin
      check("req_in_reset", 32'(mem_req), 32'd0);
    end else if (last_req && mem_ack) begin
      check("req_gap", 32'(mem_req), 32'd0);
    end else if (last_req) begin
      check("req_held", 32'(mem_req), 32'd1);
      if (mem_req) check("txn_stable", 32'(cur), 32'(held));
    end else if (mem_req) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL txn_unexpected: got 0x%0h, expected no request", cur);
      end else begin
        exp_t = exp_q.pop_front();
        check("txn", 32'(cur), 32'(exp_t));
      end
      held = cur;
    end
    last_req = mem_req;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    @(negedge clk);
    rst      = 1'b0;
    ack_idle = 1'b1;
    repeat (n) @(negedge clk);
    exp_q.delete();
    check("rst_req",  32'(mem_req),  32'd0);
    check("rst_we",   32'(mem_we),   32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_pc",   32'(pc_o),     32'd0);
    check("rst_ac",   32'(ac_o),     32'd0);
    check("rst_halt", 32'(HALT),     32'd0);
  endtask

  task automatic release_reset();
    ack_idle = 1'b0;
    rst      = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < MEMN; i++) mem[i] = '0;
  endtask

  task automatic run_until_halt(input int budget);
    int n;
    n = 0;
    while (!HALT && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", 32'(HALT), 32'd1);
    repeat (20) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // LDA 30; ADD 31; STO 29; HLT  with 0x0F + (all-ones - 10) = 0x04 (wraps)
  task automatic load_prog1();
    logic [DW-1:0] v;
    clear_mem();
    mem[0]  = enc(3'd5, AW'(30));
    mem[1]  = enc(3'd2, AW'(31));
    mem[2]  = enc(3'd6, AW'(29));
    mem[3]  = enc(3'd0, AW'(0));
    mem[30] = DW'(8'h0F);
    v = '1;
    mem[31] = v - DW'(10);
  endtask

  task automatic push_prog1();
    push_rd(0); push_rd(30);
    push_rd(1); push_rd(31);
    push_rd(2); push_wr(29, DW'(8'h04));
    push_rd(3);
  endtask

  task automatic check_prog1();
    check("p1_halt", 32'(HALT),    32'd1);
    check("p1_pc",   32'(pc_o),    32'd3);
    check("p1_ac",   32'(ac_o),    32'h04);
    check("p1_mem29", 32'(mem[29]), 32'h04);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    max_wait    = 0;
    stall_we    = 1'b0;
    ack_idle    = 1'b1;
    rst         = 1'b0;
`ifdef ACC_CPU_RESUME_EN
    resume      = 1'b0;
`endif

    // 1) reset with ack held high, then the basic program at zero wait
    do_reset(3);
    load_prog1();
    push_prog1();
    release_reset();
    run_until_halt(300);
    check_prog1();

    // 2) same program with random 0..4 wait states
    do_reset(2);
    load_prog1();
    max_wait = 4;
    push_prog1();
    release_reset();
    run_until_halt(600);
    check_prog1();
    max_wait = 0;

    // 3) SKZ taken / not taken / wrap at the top of the address space
    do_reset(2);
    clear_mem();
    mem[0]  = enc(3'd7, AW'(2));    // JMP 2
    mem[1]  = enc(3'd0, AW'(0));    // HLT (reached after the wrap)
    mem[2]  = enc(3'd5, AW'(28));   // LDA 28 -> 0
    mem[3]  = enc(3'd3, AW'(28));   // AND 28 -> 0
    mem[4]  = enc(3'd1, AW'(0));    // SKZ, ac=0 -> 6
    mem[5]  = enc(3'd0, AW'(0));
    mem[6]  = enc(3'd5, AW'(27));   // LDA 27 -> 1
    mem[7]  = enc(3'd4, AW'(26));   // XOR 26 -> 0x5B
    mem[8]  = enc(3'd1, AW'(0));    // SKZ, ac!=0 -> 9
    mem[9]  = enc(3'd5, AW'(28));   // LDA 28 -> 0
    mem[10] = enc(3'd7, AMAX);      // JMP max
    mem[AMAX] = enc(3'd1, AW'(0));  // SKZ, ac=0 -> wraps to 1
    mem[26] = DW'(8'h5A);
    mem[27] = DW'(1);
    mem[28] = '0;
    push_rd(0);  push_rd(2);  push_rd(28); push_rd(3);  push_rd(28);
    push_rd(4);  push_rd(6);  push_rd(27); push_rd(7);  push_rd(26);
    push_rd(8);  push_rd(9);  push_rd(28); push_rd(10); push_rd(int'(AMAX));
    push_rd(1);
    release_reset();
    run_until_halt(600);
    check("skz_pc", 32'(pc_o), 32'd1);
    check("skz_ac", 32'(ac_o), 32'd0);

    // 4) reset while a store is waiting for ack
    do_reset(2);
    load_prog1();
    stall_we = 1'b1;
    push_prog1();
    release_reset();
    begin
      int n;
      n = 0;
      while (!(mem_req && mem_we) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("opwr_reached", 32'(mem_req && mem_we), 32'd1);
    end
    repeat (3) @(negedge clk);
    do_reset(2);
    check("abandoned_store", 32'(mem[29]), 32'd0);
    stall_we = 1'b0;
    push_prog1();
    release_reset();
    run_until_halt(300);
    check_prog1();

    // 5) halt at 0x10, then resume (or stay halted without the option)
    do_reset(2);
    clear_mem();
    mem[0]  = enc(3'd7, AW'(16));   // JMP 0x10
    mem[16] = enc(3'd0, AW'(0));    // HLT
    mem[17] = enc(3'd0, AW'(0));    // HLT
    push_rd(0);
    push_rd(16);
    release_reset();
    run_until_halt(300);
    check("halt_pc", 32'(pc_o), 32'd16);
`ifdef ACC_CPU_RESUME_EN
    push_rd(17);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    check("resume_halt_low", 32'(HALT), 32'd0);
    check("resume_pc", 32'(pc_o), 32'd17);
    run_until_halt(300);
    check("resume_final_pc", 32'(pc_o), 32'd17);
`else
    begin
      int held_cnt;
      held_cnt = 0;
      repeat (100) begin
        @(negedge clk);
        if (HALT) held_cnt++;
      end
      check("halt_held_100", 32'(held_cnt), 32'd100);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
